// File: rtl/vic_pkg.sv
// Shared constants for the vectored interrupt controller.
package vic_pkg;

  localparam int unsigned WORD_W = 12;

  localparam logic [WORD_W-1:0] NO_INTERRUPT = 12'o7777;
  localparam logic [WORD_W-1:0] ALL_SEL      = 12'o7777;

  localparam logic [2:0] CMD_ACK     = 3'd0;
  localparam logic [2:0] CMD_EOI     = 3'd1;
  localparam logic [2:0] CMD_DISMISS = 3'd2;
  localparam logic [2:0] CMD_CREATE  = 3'd3;
  localparam logic [2:0] CMD_MASK    = 3'd4;
  localparam logic [2:0] CMD_UNMASK  = 3'd5;

endpackage

// File: rtl/irq_line_sync.sv
// Per-line synchroniser with registered level and rising-edge detect.
module irq_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Shift the asynchronous line through the synchroniser, keep last level for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], irq};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = chain[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/vectored_interrupt_controller.sv
// Vectored interrupt controller: masked, nested hardware lines plus a
// software-vector FIFO, presented to the CPU through a registered vector.
module vectored_interrupt_controller
  import vic_pkg::*;
#(
  parameter int unsigned      LINES       = 24,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [LINES-1:0] LEVEL_MASK  = {LINES{1'b0}},
  parameter logic [LINES-1:0] RESET_MASK  = {LINES{1'b1}},
  parameter int unsigned      SW_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LINES-1:0]  irq,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_op,
  input  logic [WORD_W-1:0] data_in,
  output logic [WORD_W-1:0] next_interrupt,
  output logic              irq_req,
  output logic              sw_full,
  output logic              sw_overflow
);

  localparam int unsigned PTR_W = $clog2(SW_DEPTH) + 1;
  localparam int unsigned IDX_W = PTR_W - 1;

  logic [LINES-1:0]  line_level, line_rise;
  logic [LINES-1:0]  pending, pending_n;
  logic [LINES-1:0]  mask, mask_n;
  logic [LINES-1:0]  in_service, in_service_n;
  logic              sw_in_service, sw_in_service_n;
  logic              overflow_n;
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [WORD_W-1:0] fifo_mem [SW_DEPTH];
  logic [WORD_W-1:0] fifo_head;
  logic              fifo_empty, push;

  logic              is_all, is_sw;
  logic              op_eoi, op_dismiss, op_create, op_mask, op_unmask;
  logic              do_ack, ack_hw, ack_sw;
  logic [LINES-1:0]  sel_line, ack_line, edge_clr;
  logic [LINES-1:0]  eligible;
  logic [WORD_W-1:0] next_vec;

  for (genvar g = 0; g < LINES; g++) begin : g_sync
    irq_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .irq   (irq[g]),
      .level (line_level[g]),
      .rise  (line_rise[g])
    );
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign sw_full    = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                      (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr[IDX_W-1:0]];

  // Decode the command and the line it selects; ACK acts on the presented vector
  always_comb begin
    is_all     = (data_in == ALL_SEL);
    is_sw      = (data_in >= WORD_W'(LINES)) && !is_all;
    op_eoi     = cmd_valid && (cmd_op == CMD_EOI);
    op_dismiss = cmd_valid && (cmd_op == CMD_DISMISS);
    op_create  = cmd_valid && (cmd_op == CMD_CREATE);
    op_mask    = cmd_valid && (cmd_op == CMD_MASK);
    op_unmask  = cmd_valid && (cmd_op == CMD_UNMASK);
    do_ack     = cmd_valid && (cmd_op == CMD_ACK) && irq_req;
    ack_hw     = do_ack && (next_interrupt < WORD_W'(LINES));
    ack_sw     = do_ack && !ack_hw;
    sel_line   = '0;
    ack_line   = '0;
    for (int unsigned i = 0; i < LINES; i++) begin
      sel_line[i] = is_all || (data_in == WORD_W'(i));
      ack_line[i] = ack_hw && (next_interrupt == WORD_W'(i));
    end
  end

  // Next state of pending, mask, in-service and the software FIFO pointers
  always_comb begin
    edge_clr = ack_line | (op_dismiss ? sel_line : '0);
    for (int unsigned i = 0; i < LINES; i++) begin
      // An arrival in the same cycle as a clear wins
      pending_n[i] = LEVEL_MASK[i] ? line_level[i]
                                   : ((pending[i] & ~edge_clr[i]) | line_rise[i]);
    end

    mask_n = mask;
    if (op_mask)   mask_n = mask & ~sel_line;
    if (op_unmask) mask_n = mask | sel_line;

    in_service_n = in_service | ack_line;
    if (op_eoi) in_service_n = in_service_n & ~sel_line;

    sw_in_service_n = sw_in_service;
    if (ack_sw) sw_in_service_n = 1'b1;
    if (op_eoi && (is_sw || is_all)) sw_in_service_n = 1'b0;

    push       = op_create && is_sw && !sw_full;
    overflow_n = sw_overflow || (op_create && is_sw && sw_full);
    wr_ptr_n   = wr_ptr + PTR_W'(push);
    rd_ptr_n   = rd_ptr + PTR_W'(ack_sw);
    if (op_dismiss && is_all) begin
      rd_ptr_n   = wr_ptr;
      overflow_n = 1'b0;
    end
  end

  // Nested eligibility: only lines below the lowest in-service line compete; lowest index wins
  always_comb begin
    logic seen;
    logic found;
    seen     = 1'b0;
    found    = 1'b0;
    eligible = '0;
    next_vec = NO_INTERRUPT;
    for (int unsigned i = 0; i < LINES; i++) begin
      seen        = seen | in_service[i];
      eligible[i] = pending[i] & mask[i] & ~seen;
      if (eligible[i] && !found) begin
        found    = 1'b1;
        next_vec = WORD_W'(i);
      end
    end
    if (!found && !fifo_empty && (in_service == '0) && !sw_in_service)
      next_vec = fifo_head;
  end

  // Controller state and registered presentation to the CPU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending        <= '0;
      mask           <= RESET_MASK;
      in_service     <= '0;
      sw_in_service  <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      sw_overflow    <= 1'b0;
      next_interrupt <= NO_INTERRUPT;
      irq_req        <= 1'b0;
    end else begin
      pending        <= pending_n;
      mask           <= mask_n;
      in_service     <= in_service_n;
      sw_in_service  <= sw_in_service_n;
      wr_ptr         <= wr_ptr_n;
      rd_ptr         <= rd_ptr_n;
      sw_overflow    <= overflow_n;
      next_interrupt <= next_vec;
      irq_req        <= (next_vec != NO_INTERRUPT);
    end
  end

  // Software FIFO storage; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[IDX_W-1:0]] <= data_in;
  end

endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// Directed bench for the vectored interrupt controller (6 lines, line 3 level).
module tb_vectored_interrupt_controller;

  localparam logic [2:0] OP_ACK     = 3'd0;
  localparam logic [2:0] OP_EOI     = 3'd1;
  localparam logic [2:0] OP_DISMISS = 3'd2;
  localparam logic [2:0] OP_CREATE  = 3'd3;
  localparam logic [2:0] OP_MASK    = 3'd4;
  localparam logic [2:0] OP_UNMASK  = 3'd5;
  localparam logic [11:0] NONE      = 12'o7777;

  logic        clk;
  logic        rst_n;
  logic [5:0]  irq;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [11:0] data_in;
  logic [11:0] next_interrupt;
  logic        irq_req;
  logic        sw_full;
  logic        sw_overflow;

  int checks = 0;
  int passed = 0;

  vectored_interrupt_controller #(
    .LINES       (6),
    .SYNC_STAGES (2),
    .LEVEL_MASK  (6'b001000),
    .RESET_MASK  (6'b111111),
    .SW_DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .irq            (irq),
    .cmd_valid      (cmd_valid),
    .cmd_op         (cmd_op),
    .data_in        (data_in),
    .next_interrupt (next_interrupt),
    .irq_req        (irq_req),
    .sw_full        (sw_full),
    .sw_overflow    (sw_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] op, input logic [11:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    data_in   = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    data_in   = '0;
  endtask

  task automatic test_reset;
    tick(2);
    checks++;
    if (next_interrupt !== NONE) $display("FAIL reset_vec: got %o want %o", next_interrupt, NONE);
    else passed++;
    checks++;
    if ({irq_req, sw_full, sw_overflow} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {irq_req, sw_full, sw_overflow});
    else passed++;
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic;
    irq[2] = 1'b1;
    tick(3);
    irq[2] = 1'b0;
    checks++;
    if (irq_req !== 1'b0) $display("FAIL basic_early: irq_req got %b want 0", irq_req);
    else passed++;
    tick(1);
    checks++;
    if (next_interrupt !== 12'd2 || irq_req !== 1'b1)
      $display("FAIL basic_present: got %o/%b want 2/1", next_interrupt, irq_req);
    else passed++;
    cmd(OP_ACK, 12'd0);
    tick(1);
    checks++;
    if (next_interrupt !== NONE) $display("FAIL basic_ack: got %o want %o", next_interrupt, NONE);
    else passed++;
    cmd(OP_EOI, 12'd2);
    tick(1);
    checks++;
    if (next_interrupt !== NONE || irq_req !== 1'b0)
      $display("FAIL basic_eoi: got %o/%b want %o/0", next_interrupt, irq_req, NONE);
    else passed++;
  endtask

  task automatic test_nesting;
    irq[2] = 1'b1;
    tick(3);
    irq[2] = 1'b0;
    tick(1);
    cmd(OP_ACK, 12'd0);
    irq[0] = 1'b1;
    irq[4] = 1'b1;
    tick(3);
    irq[0] = 1'b0;
    irq[4] = 1'b0;
    tick(1);
    checks++;
    if (next_interrupt !== 12'd0) $display("FAIL nest_preempt: got %o want 0", next_interrupt);
    else passed++;
    cmd(OP_ACK, 12'd0);
    tick(1);
    checks++;
    if (next_interrupt !== NONE) $display("FAIL nest_ack0: got %o want %o", next_interrupt, NONE);
    else passed++;
    cmd(OP_EOI, 12'd0);
    tick(1);
    checks++;
    if (next_interrupt !== NONE) $display("FAIL nest_blocked: got %o want %o", next_interrupt, NONE);
    else passed++;
    cmd(OP_EOI, 12'd2);
    tick(1);
    checks++;
    if (next_interrupt !== 12'd4) $display("FAIL nest_unblock: got %o want 4", next_interrupt);
    else passed++;
    cmd(OP_ACK, 12'd0);
    cmd(OP_EOI, 12'd4);
    tick(1);
  endtask

  task automatic test_level;
    irq[3] = 1'b1;
    tick(4);
    checks++;
    if (next_interrupt !== 12'd3) $display("FAIL level_present: got %o want 3", next_interrupt);
    else passed++;
    cmd(OP_ACK, 12'd0);
    tick(1);
    checks++;
    if (next_interrupt !== NONE) $display("FAIL level_ack: got %o want %o", next_interrupt, NONE);
    else passed++;
    cmd(OP_EOI, 12'd3);
    tick(1);
    checks++;
    if (next_interrupt !== 12'd3) $display("FAIL level_repres: got %o want 3", next_interrupt);
    else passed++;
    cmd(OP_DISMISS, 12'd3);
    tick(1);
    checks++;
    if (next_interrupt !== 12'd3) $display("FAIL level_dismiss: got %o want 3", next_interrupt);
    else passed++;
    irq[3] = 1'b0;
    tick(4);
    checks++;
    if (next_interrupt !== NONE || irq_req !== 1'b0)
      $display("FAIL level_drop: got %o/%b want %o/0", next_interrupt, irq_req, NONE);
    else passed++;
  endtask

  task automatic test_mask;
    cmd(OP_MASK, 12'd1);
    irq[1] = 1'b1;
    tick(3);
    irq[1] = 1'b0;
    tick(2);
    checks++;
    if (next_interrupt !== NONE) $display("FAIL mask_hidden: got %o want %o", next_interrupt, NONE);
    else passed++;
    cmd(OP_UNMASK, 12'd1);
    checks++;
    if (next_interrupt !== NONE) $display("FAIL unmask_lag: got %o want %o", next_interrupt, NONE);
    else passed++;
    tick(1);
    checks++;
    if (next_interrupt !== 12'd1) $display("FAIL unmask_present: got %o want 1", next_interrupt);
    else passed++;
    cmd(OP_ACK, 12'd0);
    cmd(OP_EOI, 12'd1);
    tick(1);
  endtask

  task automatic fill_fifo;
    cmd(OP_CREATE, 12'o7000);
    cmd(OP_CREATE, 12'o7001);
    cmd(OP_CREATE, 12'o7002);
    cmd(OP_CREATE, 12'o7003);
    cmd(OP_CREATE, 12'o7004);
  endtask

  task automatic test_software;
    cmd(OP_CREATE, 12'd3);
    cmd(OP_CREATE, 12'o7777);
    tick(1);
    checks++;
    if (next_interrupt !== NONE) $display("FAIL create_ignored: got %o want %o", next_interrupt, NONE);
    else passed++;
    fill_fifo();
    checks++;
    if ({sw_full, sw_overflow} !== 2'b11)
      $display("FAIL sw_fullflags: got %b want 11", {sw_full, sw_overflow});
    else passed++;
    checks++;
    if (next_interrupt !== 12'o7000) $display("FAIL sw_head: got %o want 7000", next_interrupt);
    else passed++;
    cmd(OP_ACK, 12'd0);
    tick(1);
    checks++;
    if (next_interrupt !== NONE || sw_full !== 1'b0)
      $display("FAIL sw_ack: got %o/%b want %o/0", next_interrupt, sw_full, NONE);
    else passed++;
    cmd(OP_EOI, 12'o7000);
    tick(1);
    checks++;
    if (next_interrupt !== 12'o7001) $display("FAIL sw_eoi: got %o want 7001", next_interrupt);
    else passed++;
    cmd(OP_DISMISS, 12'o7777);
    tick(1);
    checks++;
    if (next_interrupt !== NONE || sw_overflow !== 1'b0 || sw_full !== 1'b0)
      $display("FAIL sw_flush: got %o/%b/%b want %o/0/0", next_interrupt, sw_overflow, sw_full, NONE);
    else passed++;
  endtask

  task automatic test_race_and_reset;
    fill_fifo();
    irq[5] = 1'b1;
    tick(2);
    cmd(OP_DISMISS, 12'd5);
    irq[5] = 1'b0;
    tick(1);
    checks++;
    if (next_interrupt !== 12'd5) $display("FAIL race_arrival: got %o want 5", next_interrupt);
    else passed++;
    cmd_valid = 1'b1;
    cmd_op    = OP_ACK;
    data_in   = '0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (next_interrupt !== NONE || {irq_req, sw_full, sw_overflow} !== 3'b000)
      $display("FAIL async_reset: got %o/%b want %o/000", next_interrupt,
               {irq_req, sw_full, sw_overflow}, NONE);
    else passed++;
    cmd_valid = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(4);
    checks++;
    if (next_interrupt !== NONE || irq_req !== 1'b0)
      $display("FAIL post_reset: got %o/%b want %o/0", next_interrupt, irq_req, NONE);
    else passed++;
  endtask

  initial begin
    rst_n     = 1'b0;
    irq       = '0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    data_in   = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_nesting();
    test_level();
    test_mask();
    test_software();
    test_race_and_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
